// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light sensor front end: default widths,
// debounce/departure timing and the direction index map.
package traffic_pkg;

    localparam int CNT_W_DEF           = 3;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DEPART_CYCLES_DEF   = 2;

    localparam int NUM_DIR = 4;
    localparam int DIR_N   = 0;
    localparam int DIR_S   = 1;
    localparam int DIR_E   = 2;
    localparam int DIR_W   = 3;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a hold-time debouncer; rise_o marks the
// cycle in which the accepted level is about to switch from 0 to 1.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          update_s;

    // Next-state for the debounced level and its hold counter
    always_comb begin
        update_s = (sync2_q != db_q) && (cnt_q == CNT_LAST);
        if (sync2_q == db_q) begin
            cnt_d = {CW{1'b0}};
            db_d  = db_q;
        end else if (update_s) begin
            cnt_d = {CW{1'b0}};
            db_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
            db_d  = db_q;
        end
    end

    // The pulse is decoded from registers so the counting logic upstream can
    // react in the same edge that db flips.
    assign rise_o = update_s & sync2_q;

    // Synchroniser and debounce state
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions loop detectors and pedestrian buttons into saturating vehicle
// counts (drained while green) and latched crossing requests for the FSM.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DEPART_CYCLES   = DEPART_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             loop_n_i,
    input  logic             loop_s_i,
    input  logic             loop_e_i,
    input  logic             loop_w_i,
    input  logic             ped_raw_ns_i,
    input  logic             ped_raw_ew_i,
    input  logic             green_northsouth_i,
    input  logic             green_eastwest_i,
    output logic [CNT_W-1:0] vcount_northbound_o,
    output logic [CNT_W-1:0] vcount_southbound_o,
    output logic [CNT_W-1:0] vcount_eastbound_o,
    output logic [CNT_W-1:0] vcount_westbound_o,
    output logic             ped_button_ns_o,
    output logic             ped_button_ew_o,
    output logic [3:0]       overflow_o
);

    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TW-1:0]    T_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};

    logic [5:0] raw_s;
    logic [5:0] rise_s;

    assign raw_s = {ped_raw_ew_i, ped_raw_ns_i, loop_w_i, loop_e_i, loop_s_i, loop_n_i};

    for (genvar g = 0; g < 6; g++) begin : g_db
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock_i  (clock_i),
            .reset_n_i(reset_n_i),
            .raw_i    (raw_s[g]),
            .rise_o   (rise_s[g])
        );
    end

    logic [CNT_W-1:0] count_q [NUM_DIR];
    logic [CNT_W-1:0] count_d [NUM_DIR];
    logic [TW-1:0]    timer_q [NUM_DIR];
    logic [TW-1:0]    timer_d [NUM_DIR];
    logic [3:0]       ovf_q, ovf_d;
    logic [1:0]       ped_q, ped_d;
    logic [1:0]       green_prev_q, green_rise_s;
    logic [3:0]       green_dir_s, run_s, depart_s;

    // Departure timers, count arithmetic and request latching
    always_comb begin
        green_rise_s = {green_eastwest_i, green_northsouth_i} & ~green_prev_q;
        ovf_d        = ovf_q;
        ped_d        = ped_q;
        green_dir_s  = 4'b0000;
        run_s        = 4'b0000;
        depart_s     = 4'b0000;
        for (int d = 0; d < NUM_DIR; d++) begin
            green_dir_s[d] = (d == DIR_N || d == DIR_S) ? green_northsouth_i : green_eastwest_i;
            run_s[d]       = green_dir_s[d] && (count_q[d] != C_ZERO);
            depart_s[d]    = run_s[d] && (timer_q[d] == T_LAST);
            if (run_s[d] && !depart_s[d]) begin
                timer_d[d] = timer_q[d] + TW'(1);
            end else begin
                timer_d[d] = {TW{1'b0}};
            end
            if (rise_s[d] && !depart_s[d]) begin
                if (count_q[d] == C_MAX) begin
                    count_d[d] = count_q[d];
                    ovf_d[d]   = 1'b1;
                end else begin
                    count_d[d] = count_q[d] + CNT_W'(1);
                end
            end else if (depart_s[d] && !rise_s[d]) begin
                count_d[d] = count_q[d] - CNT_W'(1);
            end else begin
                count_d[d] = count_q[d];
            end
        end
        // A fresh press wins over the clear caused by the same-cycle green rise
        for (int p = 0; p < 2; p++) begin
            if (rise_s[4 + p]) begin
                ped_d[p] = 1'b1;
            end else if (green_rise_s[p]) begin
                ped_d[p] = 1'b0;
            end else begin
                ped_d[p] = ped_q[p];
            end
        end
    end

    // State registers; every output is driven straight from here
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int d = 0; d < NUM_DIR; d++) begin
                count_q[d] <= C_ZERO;
                timer_q[d] <= {TW{1'b0}};
            end
            ovf_q        <= 4'b0000;
            ped_q        <= 2'b00;
            green_prev_q <= 2'b00;
        end else begin
            for (int d = 0; d < NUM_DIR; d++) begin
                count_q[d] <= count_d[d];
                timer_q[d] <= timer_d[d];
            end
            ovf_q        <= ovf_d;
            ped_q        <= ped_d;
            green_prev_q <= {green_eastwest_i, green_northsouth_i};
        end
    end

    assign vcount_northbound_o = count_q[DIR_N];
    assign vcount_southbound_o = count_q[DIR_S];
    assign vcount_eastbound_o  = count_q[DIR_E];
    assign vcount_westbound_o  = count_q[DIR_W];
    assign ped_button_ns_o     = ped_q[0];
    assign ped_button_ew_o     = ped_q[1];
    assign overflow_o          = ovf_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench: each scenario queues expected output values tagged with
// the clock edge at which they must be visible, then drains them as it runs.
module tb_traffic_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       l_n, l_s, l_e, l_w, p_ns, p_ew, g_ns, g_ew;
    logic [2:0] vc_n, vc_s, vc_e, vc_w;
    logic       pb_ns, pb_ew;
    logic [3:0] ovf;

    localparam int S_N = 0, S_S = 1, S_E = 2, S_W = 3, S_PN = 4, S_PE = 5, S_OV = 6;

    typedef struct {
        int due;
        int sel;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner dut (
        .clock_i            (clk),
        .reset_n_i          (rst_n),
        .loop_n_i           (l_n),
        .loop_s_i           (l_s),
        .loop_e_i           (l_e),
        .loop_w_i           (l_w),
        .ped_raw_ns_i       (p_ns),
        .ped_raw_ew_i       (p_ew),
        .green_northsouth_i (g_ns),
        .green_eastwest_i   (g_ew),
        .vcount_northbound_o(vc_n),
        .vcount_southbound_o(vc_s),
        .vcount_eastbound_o (vc_e),
        .vcount_westbound_o (vc_w),
        .ped_button_ns_o    (pb_ns),
        .ped_button_ew_o    (pb_ew),
        .overflow_o         (ovf)
    );

    function automatic int obs(input int sel);
        case (sel)
            S_N:     return int'(vc_n);
            S_S:     return int'(vc_s);
            S_E:     return int'(vc_e);
            S_W:     return int'(vc_w);
            S_PN:    return int'(pb_ns);
            S_PE:    return int'(pb_ew);
            S_OV:    return int'(ovf);
            default: return -1;
        endcase
    endfunction

    function automatic string nm(input int sel);
        case (sel)
            S_N:     return "vcount_n";
            S_S:     return "vcount_s";
            S_E:     return "vcount_e";
            S_W:     return "vcount_w";
            S_PN:    return "ped_ns";
            S_PE:    return "ped_ew";
            S_OV:    return "overflow";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int due, input int sel, input int val);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // One active edge, then return at the following falling edge for sampling
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        {l_n, l_s, l_e, l_w, p_ns, p_ew, g_ns, g_ew} = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int sel, input int hi, input int lo);
        case (sel)
            S_N:     l_n = 1'b1;
            S_S:     l_s = 1'b1;
            S_E:     l_e = 1'b1;
            default: l_w = 1'b1;
        endcase
        repeat (hi) tick();
        {l_n, l_s, l_e, l_w} = 4'b0000;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        int c;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            {l_n, l_s, l_e, l_w} = (i == 0) ? 4'b1111 : 4'b0101;
            {p_ns, p_ew, g_ns, g_ew} = 4'b1111;
            tick();
        end
        for (int s = S_N; s <= S_OV; s++) begin
            checks++;
            if (obs(s) !== 0) begin
                errors++;
                $display("FAIL reset_%s got %0d want 0", nm(s), obs(s));
            end
        end
        {l_n, l_s, l_e, p_ns, p_ew, g_ns, g_ew} = 7'b0000000;
        l_w   = 1'b1;
        rst_n = 1'b1;
        c = cyc;
        push(c + 5, S_W, 0);
        push(c + 6, S_W, 1);
        push(c + 9, S_W, 1);
        repeat (10) begin
            tick();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL reset_release %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        l_w = 1'b0;
    endtask

    task automatic test_arrival();
        int c;
        do_reset();
        pulse(S_N, 3, 8);
        checks++;
        if (vc_n !== 3'd0) begin
            errors++;
            $display("FAIL glitch_ignored got %0d want 0", vc_n);
        end
        c   = cyc;
        l_n = 1'b1;
        push(c + 5, S_N, 0);
        push(c + 6, S_N, 1);
        push(c + 18, S_N, 1);
        push(c + 18, S_OV, 0);
        repeat (18) begin
            tick();
            if (cyc == c + 10) l_n = 1'b0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL arrival %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic test_departure();
        int c;
        do_reset();
        repeat (3) pulse(S_E, 6, 6);
        checks++;
        if (vc_e !== 3'd3) begin
            errors++;
            $display("FAIL preload_e got %0d want 3", vc_e);
        end
        c    = cyc;
        g_ew = 1'b1;
        push(c + 1, S_E, 3);
        push(c + 2, S_E, 2);
        push(c + 3, S_E, 2);
        push(c + 4, S_E, 1);
        push(c + 6, S_E, 0);
        push(c + 9, S_E, 0);
        push(c + 9, S_N, 0);
        repeat (10) begin
            tick();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL departure %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        g_ew = 1'b0;
        pulse(S_E, 6, 6);
        // Two one-cycle green slices must not add up to a departure
        c = cyc;
        push(c + 6, S_E, 1);
        repeat (6) begin
            g_ew = (cyc == c || cyc == c + 2) ? 1'b1 : 1'b0;
            tick();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL partial_green %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        g_ew = 1'b0;
    endtask

    task automatic test_simultaneous();
        int c;
        do_reset();
        repeat (2) pulse(S_E, 6, 6);
        c   = cyc;
        l_e = 1'b1;
        push(c + 5, S_E, 2);
        push(c + 6, S_E, 2);
        push(c + 6, S_OV, 0);
        push(c + 7, S_E, 2);
        push(c + 8, S_E, 1);
        push(c + 10, S_E, 0);
        repeat (10) begin
            tick();
            if (cyc == c + 4) g_ew = 1'b1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL simultaneous %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        {l_e, g_ew} = 2'b00;
        repeat (6) tick();
    endtask

    task automatic test_saturation();
        int c;
        do_reset();
        repeat (7) pulse(S_S, 5, 5);
        checks++;
        if (vc_s !== 3'd7 || ovf !== 4'b0000) begin
            errors++;
            $display("FAIL sat_at_max got %0d/%b want 7/0000", vc_s, ovf);
        end
        repeat (2) pulse(S_S, 5, 5);
        checks++;
        if (vc_s !== 3'd7 || ovf !== 4'b0010) begin
            errors++;
            $display("FAIL sat_overflow got %0d/%b want 7/0010", vc_s, ovf);
        end
        c    = cyc;
        g_ns = 1'b1;
        push(c + 2, S_S, 6);
        push(c + 6, S_S, 4);
        push(c + 6, S_N, 0);
        push(c + 6, S_OV, 2);
        repeat (6) begin
            tick();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL saturation %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        g_ns = 1'b0;
    endtask

    task automatic test_pedestrian();
        int c;
        do_reset();
        c = cyc;
        // press, release, serve, held-through-green, then press landing on the clear edge
        push(c + 5, S_PN, 0);
        push(c + 6, S_PN, 1);
        push(c + 14, S_PN, 1);
        push(c + 15, S_PN, 0);
        push(c + 18, S_PN, 0);
        push(c + 30, S_PN, 1);
        push(c + 33, S_PN, 0);
        push(c + 43, S_PN, 0);
        push(c + 56, S_PN, 1);
        push(c + 59, S_PN, 1);
        push(c + 59, S_PE, 0);
        repeat (60) begin
            p_ns = (cyc < c + 6) || (cyc >= c + 24 && cyc < c + 44) || (cyc >= c + 50);
            g_ns = (cyc >= c + 14 && cyc < c + 18) || (cyc >= c + 32 && cyc < c + 44) || (cyc >= c + 55);
            tick();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    checks++;
                    if (obs(sb[i].sel) !== sb[i].val) begin
                        errors++;
                        $display("FAIL pedestrian %s cyc %0d got %0d want %0d", nm(sb[i].sel), cyc, obs(sb[i].sel), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        {p_ns, g_ns} = 2'b00;
    endtask

    initial begin
        {l_n, l_s, l_e, l_w, p_ns, p_ew, g_ns, g_ew} = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_arrival();
        test_departure();
        test_simultaneous();
        test_saturation();
        test_pedestrian();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
